// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response bundle between the execute stage and alu_muldiv
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [11:0]     imm;
  logic            imm_select;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, rs1, rs2, imm, imm_select, funct3, funct7, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, imm_select, funct3, funct7, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - RV32/64 I+M execute unit: 1-cycle ALU, 2-cycle multiply, iterative restoring divide
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] prod_q;
  logic              mul_hi;
  logic [XLEN-1:0]   quo, rem, dvs, dvd_orig;
  logic [SHW-1:0]    cnt;
  logic              want_rem, neg_q, neg_r, div_zero, div_ovf;

  logic                   accept, is_m, is_sub, arith;
  logic [XLEN-1:0]        op, alu_res;
  logic signed [XLEN-1:0] sra_res;
  logic [SHW-1:0]         sh;

  assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign op      = bus.imm_select ? {{(XLEN-12){bus.imm[11]}}, bus.imm} : bus.rs2;
  assign is_m    = !bus.imm_select && (bus.funct7 == 7'h01);
  assign is_sub  = !bus.imm_select && (bus.funct7 == 7'h20);
  assign arith   = bus.imm_select ? bus.imm[10] : bus.funct7[5];
  assign sh      = op[SHW-1:0];
  assign sra_res = $signed(bus.rs1) >>> sh;

  always_comb begin
    alu_res = '0;
    case (bus.funct3)
      3'd0: alu_res = is_sub ? bus.rs1 - op : bus.rs1 + op;
      3'd1: alu_res = bus.rs1 << sh;
      3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rs1) < $signed(op)};
      3'd3: alu_res = {{(XLEN-1){1'b0}}, bus.rs1 < op};
      3'd4: alu_res = bus.rs1 ^ op;
      3'd5: alu_res = arith ? sra_res : bus.rs1 >> sh;
      3'd6: alu_res = bus.rs1 | op;
      default: alu_res = bus.rs1 & op;
    endcase
  end

  // Extending both operands to 2*XLEN makes one unsigned multiplier cover all signedness mixes.
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign a_sx  = (bus.funct3 == 3'd1 || bus.funct3 == 3'd2) && bus.rs1[XLEN-1];
  assign b_sx  = (bus.funct3 == 3'd1) && op[XLEN-1];
  assign a_ext = {{XLEN{a_sx}}, bus.rs1};
  assign b_ext = {{XLEN{b_sx}}, op};
  assign prod  = a_ext * b_ext;

  logic            div_signed, rs1_neg, op_neg;
  assign div_signed = !bus.funct3[0];
  assign rs1_neg    = div_signed && bus.rs1[XLEN-1];
  assign op_neg     = div_signed && op[XLEN-1];

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] q_next, r_next, q_fix, r_fix, div_res;
  always_comb begin
    trial  = {rem, quo[XLEN-1]};
    diff   = trial - {1'b0, dvs};
    q_next = {quo[XLEN-2:0], !diff[XLEN]};
    r_next = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    q_fix  = neg_q ? -q_next : q_next;
    r_fix  = neg_r ? -r_next : r_next;
    if (div_zero)
      div_res = want_rem ? dvd_orig : '1;
    else if (div_ovf)
      div_res = want_rem ? '0 : MIN;
    else
      div_res = want_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      result_q <= '0;
      prod_q   <= '0;
      mul_hi   <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      dvd_orig <= '0;
      cnt      <= '0;
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (state == S_MUL) begin
      result_q <= mul_hi ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
      state    <= S_DONE;
    end else if (state == S_DIV) begin
      quo <= q_next;
      rem <= r_next;
      if (cnt == '0) begin
        result_q <= div_res;
        state    <= S_DONE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (accept) begin
      if (is_m && !bus.funct3[2]) begin
        prod_q <= prod;
        mul_hi <= (bus.funct3 != 3'd0);
        state  <= S_MUL;
      end else if (is_m) begin
        quo      <= rs1_neg ? -bus.rs1 : bus.rs1;
        dvs      <= op_neg ? -op : op;
        rem      <= '0;
        cnt      <= SHW'(XLEN-1);
        dvd_orig <= bus.rs1;
        want_rem <= bus.funct3[1];
        neg_q    <= rs1_neg ^ op_neg;
        neg_r    <= rs1_neg;
        div_zero <= (op == '0);
        div_ovf  <= div_signed && (bus.rs1 == MIN) && (op == '1);
        state    <= S_DIV;
      end else begin
        result_q <= alu_res;
        state    <= S_DONE;
      end
    end else if (state == S_DONE && bus.out_ready) begin
      state <= S_IDLE;
    end
  end
endmodule
